// File: rtl/intdiv_sched.sv
// intdiv_sched: round-robin, credit-controlled sharing of one fixed-latency, non-stallable divider
// between two requesters. Optional macro INTDIV_SCHED_DIVZERO_EN gives y==0 a defined result.
module intdiv_sched #(
  parameter int N     = 4,
  parameter int LAT   = 6,
  parameter int DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic signed [N-1:0] req0_x,
  input  logic signed [N-1:0] req0_y,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic signed [N-1:0] req1_x,
  input  logic signed [N-1:0] req1_y,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic signed [N-1:0] rsp0_z,
  output logic signed [N-1:0] rsp0_r,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic signed [N-1:0] rsp1_z,
  output logic signed [N-1:0] rsp1_r,
  output logic signed [N-1:0] div_x,
  output logic signed [N-1:0] div_y,
  input  logic signed [N-1:0] div_z,
  input  logic signed [N-1:0] div_r
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  logic [CW-1:0]       cred [2];
  logic                last;
  logic [1:0]          elig;
  logic [1:0]          grant;
  logic [1:0]          pop;
  logic [1:0]          push;
  logic [1:0]          rsp_vld;
  logic                accept;
  logic                sel;
  logic signed [N-1:0] x_sel;
  logic signed [N-1:0] y_sel;

  logic                tag_vld_p [LAT+1];
  logic                tag_id_p  [LAT+1];
`ifdef INTDIV_SCHED_DIVZERO_EN
  logic                tag_dz_p  [LAT+1];
  logic signed [N-1:0] tag_x_p   [LAT+1];
`endif

  logic signed [N-1:0] wb_z;
  logic signed [N-1:0] wb_r;

  logic [PW-1:0]       wr_ptr [2];
  logic [PW-1:0]       rd_ptr [2];
  logic [CW-1:0]       count  [2];
  logic signed [N-1:0] mem_z  [2][DEPTH];
  logic signed [N-1:0] mem_r  [2][DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign elig[0] = req0_valid && (cred[0] != '0);
  assign elig[1] = req1_valid && (cred[1] != '0);

  // A requester without credit is never granted, so every issued op has a FIFO slot waiting.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (elig == 2'b11) grant = last ? 2'b01 : 2'b10;
      else               grant = elig;
    end
  end

  assign accept     = |grant;
  assign sel        = grant[1];
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign x_sel      = sel ? req1_x : req0_x;
  assign y_sel      = sel ? req1_y : req0_y;

  assign rsp_vld[0] = !reset && (count[0] != '0);
  assign rsp_vld[1] = !reset && (count[1] != '0);
  assign pop        = rsp_vld & {rsp1_ready, rsp0_ready};

  always_ff @(posedge clock) begin
    if (reset) begin
      last <= 1'b1;
      for (int k = 0; k < 2; k++) cred[k] <= CRED_MAX;
    end else begin
      if (accept) last <= sel;
      for (int k = 0; k < 2; k++) begin
        case ({grant[k], pop[k]})
          2'b10:   cred[k] <= cred[k] - CW'(1);
          2'b01:   cred[k] <= cred[k] + CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Stage 0: issue register driving the divider
  always_ff @(posedge clock) begin
    if (reset) begin
      div_x <= '0;
      div_y <= '0;
    end else if (accept) begin
      div_x <= x_sel;
      div_y <= y_sel;
    end
  end

  // Stages 1..LAT: owner tags shadow the divider; stage LAT lines up with div_z/div_r
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= LAT; i++) tag_vld_p[i] <= 1'b0;
    end else begin
      tag_vld_p[0] <= accept;
      for (int i = 1; i <= LAT; i++) tag_vld_p[i] <= tag_vld_p[i-1];
    end
  end

  always_ff @(posedge clock) begin
    tag_id_p[0] <= sel;
    for (int i = 1; i <= LAT; i++) tag_id_p[i] <= tag_id_p[i-1];
`ifdef INTDIV_SCHED_DIVZERO_EN
    tag_dz_p[0] <= (y_sel == '0);
    tag_x_p[0]  <= x_sel;
    for (int i = 1; i <= LAT; i++) begin
      tag_dz_p[i] <= tag_dz_p[i-1];
      tag_x_p[i]  <= tag_x_p[i-1];
    end
`endif
  end

  always_comb begin
    wb_z = div_z;
    wb_r = div_r;
`ifdef INTDIV_SCHED_DIVZERO_EN
    if (tag_dz_p[LAT]) begin
      wb_z = '1;
      wb_r = tag_x_p[LAT];
    end
`endif
  end

  assign push[0] = tag_vld_p[LAT] && !tag_id_p[LAT];
  assign push[1] = tag_vld_p[LAT] &&  tag_id_p[LAT];

  // Write-back: per-requester result FIFOs, no fall-through
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) wr_ptr[k] <= ptr_inc(wr_ptr[k]);
        if (pop[k])  rd_ptr[k] <= ptr_inc(rd_ptr[k]);
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + CW'(1);
          2'b01:   count[k] <= count[k] - CW'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        mem_z[k][wr_ptr[k]] <= wb_z;
        mem_r[k][wr_ptr[k]] <= wb_r;
      end
    end
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_z     = mem_z[0][rd_ptr[0]];
  assign rsp0_r     = mem_r[0][rd_ptr[0]];
  assign rsp1_z     = mem_z[1][rd_ptr[1]];
  assign rsp1_r     = mem_r[1][rd_ptr[1]];

endmodule

// File: tb/tb_intdiv_sched.sv
// Directed bench for intdiv_sched with a behavioural fixed-latency divider in place of intdiv_intdiv.
module tb_intdiv_sched;

  // N=8 so that the dividends -13 and 10 are representable.
  localparam int N     = 8;
  localparam int LAT   = 6;
  localparam int DEPTH = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                req0_valid, req0_ready, req1_valid, req1_ready;
  logic signed [N-1:0] req0_x, req0_y, req1_x, req1_y;
  logic                rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic signed [N-1:0] rsp0_z, rsp0_r, rsp1_z, rsp1_r;
  logic signed [N-1:0] div_x, div_y, div_z, div_r;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  intdiv_sched #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z), .rsp0_r(rsp0_r),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z), .rsp1_r(rsp1_r),
    .div_x(div_x), .div_y(div_y), .div_z(div_z), .div_r(div_r)
  );

  // Divider stand-in: answers LAT cycles later; y==0 yields a fixed junk pair 5/3.
  logic signed [N-1:0] pz [LAT];
  logic signed [N-1:0] pr [LAT];
  always @(posedge clock) begin
    if (div_y == '0) begin
      pz[0] <= N'(5);
      pr[0] <= N'(3);
    end else begin
      pz[0] <= div_x / div_y;
      pr[0] <= div_x % div_y;
    end
    for (int i = 1; i < LAT; i++) begin
      pz[i] <= pz[i-1];
      pr[i] <= pr[i-1];
    end
  end
  assign div_z = pz[LAT-1];
  assign div_r = pr[LAT-1];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic wait_rsp(input int k, output int cyc, output int other);
    cyc = 0;
    other = 0;
    for (int i = 1; i <= 12 && cyc == 0; i++) begin
      tick;
      if ((k == 0) ? rsp1_valid : rsp0_valid) other = 1;
      if ((k == 0) ? rsp0_valid : rsp1_valid) cyc = i;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, oth, acc, ns, a0, a1, n0, n1, dbl, seen;
    int seq [4];

    req0_valid = 1'b1; req0_x = 7; req0_y = 3;
    req1_valid = 1'b0; req1_x = 0; req1_y = 1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick;
    tick;
    chk("rst_req0_ready", int'(req0_ready), 0);
    chk("rst_rsp0_valid", int'(rsp0_valid), 0);
    chk("rst_rsp1_valid", int'(rsp1_valid), 0);
    chk("rst_div_x", int'(div_x), 0);
    req0_valid = 1'b0;
    reset = 1'b0;
    tick;

    // 1: single op 7/3
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 7; req0_y = 3;
    #1;
    chk("t1_ready", int'(req0_ready), 1);
    tick;
    req0_valid = 1'b0;
    wait_rsp(0, cyc, oth);
    chk("t1_latency", cyc, 7);
    chk("t1_rsp1_idle", oth, 0);
    chk("t1_z", int'(rsp0_z), 2);
    chk("t1_r", int'(rsp0_r), 1);
    tick;
    chk("t1_popped", int'(rsp0_valid), 0);

    // 2: both requesters streaming
    do_reset;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_x = -13; req0_y = 4; req1_x = 10; req1_y = 4;
    ns = 0; a0 = 0; a1 = 0; n0 = 0; n1 = 0; dbl = 0;
    for (int c = 0; c < 32; c++) begin
      req0_valid = (c < 20);
      req1_valid = (c < 20);
      #1;
      if (req0_ready && req1_ready) dbl = 1;
      if (req0_ready || req1_ready) begin
        if (ns < 4) seq[ns] = int'(req1_ready);
        ns++;
        a0 += int'(req0_ready);
        a1 += int'(req1_ready);
      end
      if (rsp0_valid) begin
        chk("t2_rsp0_z", int'(rsp0_z), -3);
        chk("t2_rsp0_r", int'(rsp0_r), -1);
        n0++;
      end
      if (rsp1_valid) begin
        chk("t2_rsp1_z", int'(rsp1_z), 2);
        chk("t2_rsp1_r", int'(rsp1_r), 2);
        n1++;
      end
      tick;
    end
    chk("t2_grant0", seq[0], 0);
    chk("t2_grant1", seq[1], 1);
    chk("t2_grant2", seq[2], 0);
    chk("t2_grant3", seq[3], 1);
    chk("t2_one_ready", dbl, 0);
    chk("t2_accepts0", a0, 5);
    chk("t2_accepts1", a1, 5);
    chk("t2_results0", n0, a0);
    chk("t2_results1", n1, a1);

    // 3: stalled consumer limits requester 0 to its credits
    do_reset;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 7; req0_y = 3;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      acc += int'(req0_ready);
      tick;
    end
    chk("t3_accepts", acc, 2);
    chk("t3_blocked", int'(req0_ready), 0);
    chk("t3_fifo_full", int'(rsp0_valid), 1);
    rsp0_ready = 1'b1;
    #1;
    chk("t3_no_accept_on_pop", int'(req0_ready), 0);
    tick;
    rsp0_ready = 1'b0;
    #1;
    acc = int'(req0_ready);
    tick;
    for (int c = 0; c < 14; c++) begin
      acc += int'(req0_ready);
      tick;
    end
    chk("t3_one_more", acc, 1);
    req0_valid = 1'b0;

    // 4: pop and accept on one edge; push and pop on one edge
    do_reset;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 7; req0_y = 3;
    #1;
    chk("t4_acc_a", int'(req0_ready), 1);
    tick;
    req0_valid = 1'b0;
    wait_rsp(0, cyc, oth);
    chk("t4_a_latency", cyc, 7);
    req0_valid = 1'b1; req0_x = 6; req0_y = 2; rsp0_ready = 1'b1;
    #1;
    chk("t4_ready_on_pop", int'(req0_ready), 1);
    chk("t4_head_a_z", int'(rsp0_z), 2);
    tick;
    rsp0_ready = 1'b0; req0_x = -7; req0_y = 2;
    #1;
    chk("t4_cred_kept", int'(req0_ready), 1);
    tick;
    chk("t4_cred_zero", int'(req0_ready), 0);
    req0_valid = 1'b0;
    wait_rsp(0, cyc, oth);
    chk("t4_b_latency", cyc, 6);
    chk("t4_b_z", int'(rsp0_z), 3);
    chk("t4_b_r", int'(rsp0_r), 0);
    rsp0_ready = 1'b1;
    tick;
    chk("t4_c_valid", int'(rsp0_valid), 1);
    chk("t4_c_z", int'(rsp0_z), -3);
    chk("t4_c_r", int'(rsp0_r), -1);
    tick;
    chk("t4_empty", int'(rsp0_valid), 0);

    // 5: reset while four ops are in flight
    do_reset;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 7; req0_y = 3;
    req1_valid = 1'b1; req1_x = 5; req1_y = 2;
    acc = 0;
    for (int c = 0; c < 8 && acc < 4; c++) begin
      #1;
      acc += int'(req0_ready) + int'(req1_ready);
      tick;
    end
    chk("t5_four_accepts", acc, 4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick;
    tick;
    tick;
    reset = 1'b1;
    #1;
    chk("t5_rst_rsp0", int'(rsp0_valid), 0);
    tick;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (rsp0_valid || rsp1_valid) seen = 1;
    end
    chk("t5_discarded", seen, 0);
    req1_valid = 1'b1; req1_x = 5; req1_y = 2;
    #1;
    chk("t5_req1_ready", int'(req1_ready), 1);
    tick;
    req1_valid = 1'b0;
    wait_rsp(1, cyc, oth);
    chk("t5_latency", cyc, 7);
    chk("t5_rsp0_idle", oth, 0);
    chk("t5_z", int'(rsp1_z), 2);
    chk("t5_r", int'(rsp1_r), 1);
    tick;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 7; req0_y = 3;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      acc += int'(req0_ready);
      tick;
    end
    chk("t5_cred0_restored", acc, 2);
    req0_valid = 1'b0;

    // 6: divide by zero followed by a normal op, in order
    do_reset;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_x = 6; req0_y = 0;
    #1;
    chk("t6_acc_dz", int'(req0_ready), 1);
    tick;
    req0_y = 3;
    #1;
    chk("t6_acc_norm", int'(req0_ready), 1);
    tick;
    req0_valid = 1'b0;
    wait_rsp(0, cyc, oth);
    chk("t6_latency", cyc, 6);
`ifdef INTDIV_SCHED_DIVZERO_EN
    chk("t6_dz_z", int'(rsp0_z), -1);
    chk("t6_dz_r", int'(rsp0_r), 6);
`else
    chk("t6_dz_z", int'(rsp0_z), 5);
    chk("t6_dz_r", int'(rsp0_r), 3);
`endif
    rsp0_ready = 1'b1;
    tick;
    chk("t6_second_valid", int'(rsp0_valid), 1);
    chk("t6_second_z", int'(rsp0_z), 2);
    chk("t6_second_r", int'(rsp0_r), 0);
    tick;
    chk("t6_empty", int'(rsp0_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
